// File: rtl/speck_keygen.sv
// SPECK key-expansion engine: one round key per clock, streamed and kept in a register file.
// Define SPECK_KEYGEN_FLAT_OUT_EN to also expose every round key on the flat all_round_keys bus.
module speck_keygen #(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 22,
  parameter int ALPHA     = 7,
  parameter int BETA      = 2,
  parameter int IDX_W     = $clog2(ROUNDS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [KEY_WORDS*WORD_W-1:0] ukey,
  input  logic                        ukey_valid,
  output logic                        busy,
  output logic                        key_ready,
  output logic                        rk_valid,
  output logic [IDX_W-1:0]            rk_idx,
  output logic [WORD_W-1:0]           rk_word,
  input  logic                        rd_en,
  input  logic [IDX_W-1:0]            rd_addr,
  output logic [WORD_W-1:0]           rd_data
`ifdef SPECK_KEYGEN_FLAT_OUT_EN
  ,
  output logic [ROUNDS*WORD_W-1:0]    all_round_keys
`endif
);

  localparam int                LW       = KEY_WORDS - 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W:0]    ROUNDS_X = (IDX_W + 1)'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic [WORD_W-1:0]          k_q, k_d;
  logic [LW-1:0][WORD_W-1:0]  l_q, l_d, l_shift, l_load;
  logic                       rk_valid_q, rk_valid_d;
  logic [IDX_W-1:0]           rk_idx_q, rk_idx_d;
  logic [WORD_W-1:0]          rk_word_q, rk_word_d;
  logic [WORD_W-1:0]          rd_data_q;
  logic [WORD_W-1:0]          regfile_q [ROUNDS];
  logic                       rf_we;
  logic [WORD_W-1:0]          ror_l, l_new, k_next;

  // l_q[0] is the FIFO head; the freshly computed word enters at the tail.
  for (genvar gi = 0; gi < LW; gi++) begin : g_lfifo
    assign l_load[gi] = ukey[(gi + 1)*WORD_W +: WORD_W];
    if (gi == LW - 1) begin : g_tail
      assign l_shift[gi] = l_new;
    end else begin : g_body
      assign l_shift[gi] = l_q[gi + 1];
    end
  end

  always_comb begin
    ror_l  = (l_q[0] >> ALPHA) | (l_q[0] << (WORD_W - ALPHA));
    l_new  = (ror_l + k_q) ^ WORD_W'(cnt_q);
    k_next = ((k_q << BETA) | (k_q >> (WORD_W - BETA))) ^ l_new;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    l_d        = l_q;
    rk_valid_d = 1'b0;
    rk_idx_d   = rk_idx_q;
    rk_word_d  = rk_word_q;
    rf_we      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ukey_valid) begin
          state_d = S_EXPAND;
          cnt_d   = '0;
          k_d     = ukey[WORD_W-1:0];
          l_d     = l_load;
        end
      end
      S_EXPAND: begin
        rf_we      = 1'b1;
        rk_valid_d = 1'b1;
        rk_idx_d   = cnt_q;
        rk_word_d  = k_q;
        k_d        = k_next;
        l_d        = l_shift;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      l_q        <= '0;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      l_q        <= l_d;
      rk_valid_q <= rk_valid_d;
      rk_idx_q   <= rk_idx_d;
      rk_word_q  <= rk_word_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROUNDS; i++) begin
        regfile_q[i] <= '0;
      end
    end else if (rf_we) begin
      regfile_q[cnt_q] <= k_q;
    end
  end

  // No write bypass: a same-edge read of the entry being written sees the old word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= ({1'b0, rd_addr} < ROUNDS_X) ? regfile_q[rd_addr] : '0;
    end
  end

  assign busy      = (state_q == S_EXPAND);
  assign key_ready = (state_q == S_DONE);
  assign rk_valid  = rk_valid_q;
  assign rk_idx    = rk_idx_q;
  assign rk_word   = rk_word_q;
  assign rd_data   = rd_data_q;

`ifdef SPECK_KEYGEN_FLAT_OUT_EN
  for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_flat
    assign all_round_keys[gi*WORD_W +: WORD_W] = regfile_q[gi];
  end
`endif

endmodule
